// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package compositor_pkg;

  localparam int DEF_INDEX_W = 5;
  localparam int DEF_COLOR_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  // Width of a layer id that can also encode "background" (== num_layers).
  function automatic int layer_id_w(input int num_layers);
    return $clog2(num_layers + 1);
  endfunction

  // Palette contents: red ramp, falling green, scrambled blue. No entry is
  // pure white, so a flash is always distinguishable from a palette colour.
  function automatic rgb_t palette_color(input logic [7:0] idx);
    rgb_t c;
    c.r = {idx[4:0], 3'b101};
    c.g = 8'hFF - idx * 8'd7;
    c.b = idx * 8'd37;
    return c;
  endfunction

endpackage

// File: rtl/palette_rom.sv
// Shared colour palette, one synchronous read per cycle.
// Latency: 1 cycle from read_address to data_Out.
// Backpressure: none; reads every cycle.
module palette_rom
  import compositor_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic               Clk,
  input  logic [INDEX_W-1:0] read_address,
  output rgb_t               data_Out
);

  // Registered lookup; contents come from the package palette function.
  always_ff @(posedge Clk) begin
    data_Out <= palette_color(8'(read_address));
  end

endmodule

// File: rtl/layer_compositor.sv
// Priority-merges sprite layers over background, palette lookup, hit-flash.
// Latency: exactly 3 cycles from pixel/sync inputs to all outputs.
// Backpressure: none; one pixel accepted and produced every cycle.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS      = 4,
  parameter int INDEX_W         = DEF_INDEX_W,
  parameter int COLOR_W         = DEF_COLOR_W,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FLASH_FRAMES    = 8,
  localparam int ID_W           = layer_id_w(NUM_LAYERS),
  localparam int CNT_W          = $clog2(FLASH_FRAMES + 1)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_LAYERS-1:0]         layer_is_obj,
  input  logic [NUM_LAYERS*INDEX_W-1:0] layer_index,
  input  logic [NUM_LAYERS-1:0]         layer_enable,
  input  logic [INDEX_W-1:0]            bkg_index,
  input  logic [NUM_LAYERS-1:0]         flash_req,
  input  logic                          hs_in,
  input  logic                          vs_in,
  input  logic                          blank_n_in,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B,
  output logic                          hs_out,
  output logic                          vs_out,
  output logic                          blank_n_out,
  output logic [ID_W-1:0]               hit_layer
);

  logic [NUM_LAYERS-1:0] cand;
  logic [NUM_LAYERS-1:0] flash_on;
  logic [CNT_W-1:0]      cnt_q [NUM_LAYERS];
  logic                  vs_q;
  logic                  frame_tick;

  logic [INDEX_W-1:0]    win_idx_d;
  logic [ID_W-1:0]       win_id_d;
  logic [INDEX_W-1:0]    s1_idx_q;
  logic [ID_W-1:0]       s1_id_q;
  logic [2:0]            s1_sync_q;   // {hs, vs, blank_n}
  logic [ID_W-1:0]       s2_id_q;
  logic [2:0]            s2_sync_q;
  rgb_t                  rom_rgb;
  rgb_t                  rgb_d;
  logic                  flash;
  logic [COLOR_W-1:0]    rgb_q;

  // Frame tick on vs rising edge; edge register resets high so leaving
  // reset with vs already high does not look like an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vs_q <= 1'b1;
    else       vs_q <= vs_in;
  end
  assign frame_tick = vs_in & ~vs_q;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    assign cand[i] = layer_is_obj[i] & layer_enable[i] &
                     (layer_index[i*INDEX_W +: INDEX_W] != INDEX_W'(TRANSPARENT_IDX));

    // Flash timer: a request reloads (and beats a same-cycle tick), ticks count down to 0.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                                cnt_q[i] <= '0;
      else if (flash_req[i])                    cnt_q[i] <= CNT_W'(FLASH_FRAMES);
      else if (frame_tick && cnt_q[i] != '0)    cnt_q[i] <= cnt_q[i] - 1'b1;
    end

    // Odd counts blink white; bit0 set also implies the timer is running.
    assign flash_on[i] = cnt_q[i][0];
  end

  // Lowest-numbered candidate wins; background (never transparent) otherwise.
  always_comb begin
    win_idx_d = bkg_index;
    win_id_d  = ID_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx_d = layer_index[i*INDEX_W +: INDEX_W];
        win_id_d  = ID_W'(i);
      end
    end
  end

  // S1 and S2: winner and sync capture, then carried alongside the ROM read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_idx_q  <= '0;
      s1_id_q   <= '0;
      s1_sync_q <= '0;
      s2_id_q   <= '0;
      s2_sync_q <= '0;
    end else begin
      s1_idx_q  <= win_idx_d;
      s1_id_q   <= win_id_d;
      s1_sync_q <= {hs_in, vs_in, blank_n_in};
      s2_id_q   <= s1_id_q;
      s2_sync_q <= s1_sync_q;
    end
  end

  palette_rom #(.INDEX_W(INDEX_W)) u_palette_rom (
    .Clk          (Clk),
    .read_address (s1_idx_q),
    .data_Out     (rom_rgb)
  );

  // S3 colour select: flash only for sprite winners, blanking overrides all.
  always_comb begin
    flash = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s2_id_q == ID_W'(i) && flash_on[i]) flash = 1'b1;
    end
    rgb_d = flash ? WHITE : rom_rgb;
    if (!s2_sync_q[0]) rgb_d = '0;
  end

  // S3 output registers; sync resets to inactive, blank to "blanked".
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q       <= '0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      blank_n_out <= 1'b0;
      hit_layer   <= ID_W'(NUM_LAYERS);
    end else begin
      rgb_q       <= rgb_d;
      hs_out      <= s2_sync_q[2];
      vs_out      <= s2_sync_q[1];
      blank_n_out <= s2_sync_q[0];
      hit_layer   <= s2_id_q;
    end
  end

  assign VGA_R = rgb_q[23:16];
  assign VGA_G = rgb_q[15:8];
  assign VGA_B = rgb_q[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor with a frame-level reference model.
// Latency: expects every pixel's result exactly 3 cycles after it is driven.
// Backpressure: none; one pixel driven per cycle.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int FF = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  layer_is_obj = '0;
  logic [19:0] layer_index = '0;
  logic [3:0]  layer_enable = '0;
  logic [4:0]  bkg_index = '0;
  logic [3:0]  flash_req = '0;
  logic        hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        hs_out, vs_out, blank_n_out;
  logic [2:0]  hit_layer;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset),
    .layer_is_obj(layer_is_obj), .layer_index(layer_index),
    .layer_enable(layer_enable), .bkg_index(bkg_index),
    .flash_req(flash_req), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .hs_out(hs_out), .vs_out(vs_out), .blank_n_out(blank_n_out),
    .hit_layer(hit_layer)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [23:0] rgb;
    logic [2:0]  hit;
    logic        hs, vs, bl;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: flash timers per layer in frames, last vs level.
  int   mcnt[NL];
  bit   mprev_vs = 1'b1;
  bit   pend_vld = 1'b0;
  int   pend_due, pend_win, pend_idx;
  bit   pend_hs, pend_vs, pend_bl;

  function automatic logic [23:0] pal(input int i);
    logic [7:0] r, g, b;
    r = 8'((i * 8 + 5) % 256);
    g = 8'((255 - 7 * i) % 256);
    b = 8'((37 * i) % 256);
    return {r, g, b};
  endfunction

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Drive one pixel, advance the model by one cycle, and queue the result of
  // the previous pixel (whose flash check sees the timer after this cycle).
  task automatic apply(input bit we, input logic [3:0] obj, input logic [19:0] idx,
                       input logic [3:0] en, input logic [4:0] bkg, input logic [3:0] req,
                       input bit hs, input bit vs, input bit bl);
    bit   tick;
    exp_t e;
    if (we) @(negedge Clk);
    layer_is_obj = obj; layer_index = idx; layer_enable = en; bkg_index = bkg;
    flash_req = req; hs_in = hs; vs_in = vs; blank_n_in = bl;

    tick = vs && !mprev_vs;
    mprev_vs = vs;
    for (int i = 0; i < NL; i++) begin
      if (req[i])                  mcnt[i] = FF;
      else if (tick && mcnt[i] > 0) mcnt[i] = mcnt[i] - 1;
    end

    if (pend_vld) begin
      e.due = pend_due;
      e.rgb = pal(pend_idx);
      if (pend_win < NL && (mcnt[pend_win] % 2) == 1) e.rgb = 24'hFFFFFF;
      if (!pend_bl) e.rgb = 24'h0;
      e.hit = 3'(pend_win);
      e.hs = pend_hs; e.vs = pend_vs; e.bl = pend_bl;
      sb.push_back(e);
    end

    pend_win = NL;
    pend_idx = int'(bkg);
    for (int i = 0; i < NL; i++) begin
      if (obj[i] && en[i] && idx[i*5 +: 5] != 5'd0) begin
        pend_win = i;
        pend_idx = int'(idx[i*5 +: 5]);
        break;
      end
    end
    pend_hs = hs; pend_vs = vs; pend_bl = bl;
    pend_due = cyc + 3;
    pend_vld = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || hs_out !== 1'b1 || vs_out !== 1'b1 ||
        blank_n_out !== 1'b0 || hit_layer !== 3'd4) begin
      n_fail++;
      $display("FAIL %s got rgb=%h hs=%b vs=%b bl=%b hit=%0d, want rgb=000000 hs=1 vs=1 bl=0 hit=4",
               name, {VGA_R, VGA_G, VGA_B}, hs_out, vs_out, blank_n_out, hit_layer);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pend_vld = 1'b0;
    mprev_vs = 1'b1;
    for (int i = 0; i < NL; i++) mcnt[i] = 0;
  endtask

  // One frame with layer1 winning: 3 sync pixels (blanked), then 5 visible;
  // the vs rising edge may coincide with a flash request.
  task automatic frame_l1(input bit req_at_edge);
    for (int k = 0; k < 3; k++)
      apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0000, 1, 0, 0);
    apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, req_at_edge ? 4'b0010 : 4'b0000, 1, 1, 1);
    for (int k = 0; k < 4; k++)
      apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0000, 1, 1, 1);
  endtask

  // Monitor: compare the DUT output against the oldest expectation when due.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (e.due != cyc || {VGA_R, VGA_G, VGA_B} !== e.rgb || hit_layer !== e.hit ||
            hs_out !== e.hs || vs_out !== e.vs || blank_n_out !== e.bl) begin
          n_fail++;
          $display("FAIL pixel cyc=%0d due=%0d got rgb=%h hit=%0d hs/vs/bl=%b%b%b want rgb=%h hit=%0d hs/vs/bl=%b%b%b",
                   cyc, e.due, {VGA_R, VGA_G, VGA_B}, hit_layer, hs_out, vs_out, blank_n_out,
                   e.rgb, e.hit, e.hs, e.vs, e.bl);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 Reset = 1'b1;
    #2 check_reset_outputs("reset_initial");
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Priority: layers 0 (idx 3) and 2 (idx 7) cover, bkg 1.
    apply(0, 4'b0101, pk(3, 0, 7, 0), 4'hF, 5'd1, 4'b0, 1, 1, 1);
    // Transparent layer0, disabled layer1, layer3 idx 9 wins.
    apply(1, 4'b1011, pk(0, 5, 0, 9), 4'b1101, 5'd1, 4'b0, 1, 1, 1);
    // Nothing covering: background, including transparent-valued background.
    apply(1, 4'b0000, pk(3, 5, 7, 9), 4'hF, 5'd17, 4'b0, 1, 1, 1);
    apply(1, 4'b1111, pk(0, 0, 0, 0), 4'hF, 5'd0, 4'b0, 1, 1, 1);
    // Blanked pixel still reports the winner.
    apply(1, 4'b0100, pk(0, 0, 12, 0), 4'hF, 5'd3, 4'b0, 0, 1, 0);

    // Flash: request on layer1, then 9 frames of layer1 winning.
    apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0010, 1, 1, 1);
    for (int f = 0; f < 9; f++) frame_l1(1'b0);

    // Collision: bring timer to 3, then request on the tick cycle.
    apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0010, 1, 1, 1);
    for (int f = 0; f < 5; f++) frame_l1(1'b0);
    frame_l1(1'b1);
    for (int f = 0; f < 9; f++) frame_l1(1'b0);

    // Reset mid-stream with a flash running (timer at 5 when reset hits).
    apply(1, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0010, 1, 1, 1);
    for (int f = 0; f < 3; f++) frame_l1(1'b0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("reset_midstream");
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    apply(0, 4'b0010, pk(0, 6, 0, 0), 4'hF, 5'd2, 4'b0000, 1, 1, 1);
    for (int f = 0; f < 3; f++) frame_l1(1'b0);

    // Randomised traffic with sync/blank toggling and sparse flash requests.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0]  r_obj, r_en, r_req;
      logic [19:0] r_idx;
      r_obj = 4'($urandom);
      r_en  = 4'($urandom) | 4'($urandom);
      r_req = '0;
      r_idx = '0;
      for (int i = 0; i < NL; i++) begin
        r_idx[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r_req[i] = ($urandom_range(0, 30) == 0);
      end
      apply(1, r_obj, r_idx, r_en, 5'($urandom_range(0, 31)), r_req,
            $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
    end

    // Flush the last pending pixel and let the pipeline drain.
    apply(1, 4'b0000, 20'd0, 4'h0, 5'd0, 4'b0, 1, 1, 0);
    apply(1, 4'b0000, 20'd0, 4'h0, 5'd0, 4'b0, 1, 1, 0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge Clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
